// File: rtl/sim_ram_arb_pkg.sv
// rtl/sim_ram_arb_pkg.sv - shared types and grant helper for sim_ram_arbiter
// Tag and scoreboard entry layouts used by the arbiter's delay lines.
package sim_ram_arb_pkg;

  localparam int NUM_PORTS = 2;
  // Wide enough for any 32-bit byte address; narrower builds zero-extend.
  localparam int SB_WORD_W = 30;

  typedef struct packed {
    logic valid;
    logic port;
    logic write;
  } tag_t;

  typedef struct packed {
    logic                 valid;
    logic [SB_WORD_W-1:0] word;
  } sb_entry_t;

  // Round-robin pick: the port that did not win last time has priority.
  function automatic logic pick_port(input logic [NUM_PORTS-1:0] elig, input logic last);
    if (elig[0] && elig[1]) return ~last;
    return elig[1];
  endfunction

endpackage

// File: rtl/sim_ram_arbiter_if.sv
// rtl/sim_ram_arbiter_if.sv - requester-side request/response bundle for sim_ram_arbiter
// Index p of every vector belongs to requester port p.
interface sim_ram_arbiter_if
  import sim_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_PORTS-1:0]                   req_valid;
  logic [NUM_PORTS-1:0]                   req_ready;
  logic [NUM_PORTS-1:0]                   req_write;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   req_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   req_wdata;
  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] req_wstrb;
  logic [NUM_PORTS-1:0]                   resp_valid;
  logic [NUM_PORTS-1:0]                   resp_write;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_write, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_write, resp_rdata
  );

endinterface

// File: rtl/sim_ram_arb_delay_line.sv
// rtl/sim_ram_arb_delay_line.sv - fixed-depth shift register with async clear
// Exposes the oldest TAPS stages; taps[TAPS-1] is the stage about to fall off the end.
module sim_ram_arb_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1,
  parameter int TAPS  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           din,
  output logic [TAPS-1:0][WIDTH-1:0] taps
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign taps = stage[DEPTH-1 -: TAPS];

endmodule

// File: rtl/sim_ram_arbiter.sv
// rtl/sim_ram_arbiter.sv - two-port round-robin arbiter and sequencer for the fixed-latency sim RAM
// Define SIM_RAM_ARB_HAZARD_EN to stall reads hitting a word still in the RAM write delay line.
module sim_ram_arbiter
  import sim_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  sim_ram_arbiter_if.slave        bus,
  output logic [ADDR_WIDTH-1:0]   ram_raddr,
  output logic [ADDR_WIDTH-1:0]   ram_waddr,
  output logic [DATA_WIDTH/8-1:0] ram_wstrb,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  logic                 last_q;
  logic [NUM_PORTS-1:0] blocked;
  logic [NUM_PORTS-1:0] elig;
  logic                 grant_any;
  logic                 grant_port;
  logic                 grant_write;
  tag_t                 tag_in;
  tag_t                 tag_out;

  // Gating eligibility with reset keeps req_ready and every RAM pin low during reset.
  always_comb begin
    elig        = reset ? (bus.req_valid & ~(blocked & ~bus.req_write)) : '0;
    grant_any   = |elig;
    grant_port  = pick_port(elig, last_q);
    grant_write = grant_any & bus.req_write[grant_port];
    bus.req_ready = '0;
    if (grant_any) bus.req_ready[grant_port] = 1'b1;
  end

  always_comb begin
    ram_raddr = '0;
    ram_waddr = '0;
    ram_wstrb = '0;
    ram_wdata = '0;
    if (grant_write) begin
      ram_waddr = bus.req_addr[grant_port];
      ram_wstrb = bus.req_wstrb[grant_port];
      ram_wdata = bus.req_wdata[grant_port];
    end else if (grant_any) begin
      ram_raddr = bus.req_addr[grant_port];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (grant_any) begin
      last_q <= grant_port;
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = grant_any;
    tag_in.port  = grant_port;
    tag_in.write = grant_write;
  end

  sim_ram_arb_delay_line #(
    .DEPTH (READ_DELAY),
    .WIDTH ($bits(tag_t)),
    .TAPS  (1)
  ) u_tag_pipe (
    .clock (clock),
    .reset (reset),
    .din   (tag_in),
    .taps  (tag_out)
  );

  // The oldest tag lines up with the RAM's read data for the same operation.
  always_comb begin
    bus.resp_valid = '0;
    bus.resp_write = '0;
    bus.resp_rdata = '0;
    if (tag_out.valid) begin
      bus.resp_valid[tag_out.port] = 1'b1;
      bus.resp_write[tag_out.port] = tag_out.write;
      if (!tag_out.write) bus.resp_rdata[tag_out.port] = ram_rdata;
    end
  end

`ifdef SIM_RAM_ARB_HAZARD_EN
  sb_entry_t                   sb_in;
  sb_entry_t [WRITE_DELAY-1:0] sb_taps;

  always_comb begin
    sb_in       = '0;
    sb_in.valid = grant_write;
    sb_in.word  = SB_WORD_W'(bus.req_addr[grant_port][ADDR_WIDTH-1:2]);
  end

  sim_ram_arb_delay_line #(
    .DEPTH (WRITE_DELAY),
    .WIDTH ($bits(sb_entry_t)),
    .TAPS  (WRITE_DELAY)
  ) u_scoreboard (
    .clock (clock),
    .reset (reset),
    .din   (sb_in),
    .taps  (sb_taps)
  );

  // Whole-word match: a partial write still makes the word unsafe to read.
  always_comb begin
    blocked = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int s = 0; s < WRITE_DELAY; s++) begin
        if (sb_taps[s].valid &&
            sb_taps[s].word == SB_WORD_W'(bus.req_addr[p][ADDR_WIDTH-1:2])) begin
          blocked[p] = 1'b1;
        end
      end
    end
  end
`else
  assign blocked = '0;
`endif

endmodule

// File: tb/tb_sim_ram_arbiter.sv
// tb/tb_sim_ram_arbiter.sv - self-checking bench for sim_ram_arbiter
// Directed scenarios then random traffic, checked against a write-log reference model.
module tb_sim_ram_arbiter;

  localparam int AW     = 12;
  localparam int DW     = 32;
  localparam int SW     = DW / 8;
  localparam int RD     = 2;
  localparam int WD     = 2;
  localparam int NWORDS = 1 << (AW - 2);
`ifdef SIM_RAM_ARB_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sim_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [AW-1:0] ram_raddr;
  logic [AW-1:0] ram_waddr;
  logic [SW-1:0] ram_wstrb;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  sim_ram_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .READ_DELAY  (RD),
    .WRITE_DELAY (WD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .ram_raddr (ram_raddr),
    .ram_waddr (ram_waddr),
    .ram_wstrb (ram_wstrb),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Fixed-latency RAM: reads sample memory at the issuing edge, writes land WD edges later.
  logic [DW-1:0] ram_mem [NWORDS] = '{default: '0};
  logic [DW-1:0] rd_pipe [RD]     = '{default: '0};
  logic [AW-1:0] wa_pipe [WD]     = '{default: '0};
  logic [SW-1:0] ws_pipe [WD]     = '{default: '0};
  logic [DW-1:0] wd_pipe [WD]     = '{default: '0};

  always @(posedge clock) begin
    rd_pipe[0] <= ram_mem[ram_raddr[AW-1:2]];
    for (int i = 1; i < RD; i++) rd_pipe[i] <= rd_pipe[i-1];
    wa_pipe[0] <= ram_waddr;
    ws_pipe[0] <= ram_wstrb;
    wd_pipe[0] <= ram_wdata;
    for (int i = 1; i < WD; i++) begin
      wa_pipe[i] <= wa_pipe[i-1];
      ws_pipe[i] <= ws_pipe[i-1];
      wd_pipe[i] <= wd_pipe[i-1];
    end
    for (int b = 0; b < SW; b++) begin
      if (ws_pipe[WD-1][b]) ram_mem[wa_pipe[WD-1][AW-1:2]][8*b +: 8] <= wd_pipe[WD-1][8*b +: 8];
    end
  end
  assign ram_rdata = rd_pipe[RD-1];

  typedef struct {
    int            cyc;
    int            word;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } wr_t;

  typedef struct {
    int            due;
    int            port;
    logic          write;
    logic [DW-1:0] data;
  } rsp_t;

  wr_t           pend_q[$];
  wr_t           hz_q[$];
  rsp_t          exp_q[$];
  int            obs_grants[$];
  logic [DW-1:0] gold [NWORDS];
  int            cyc     = 0;
  int            n_tests = 0;
  int            n_fail  = 0;
  logic          last_m  = 1'b1;
  logic [1:0]    acc     = '0;
  int            obs_acc_cyc [2];
  logic [DW-1:0] resp_seen [2];
  int            w_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int word_of(input logic [AW-1:0] a);
    return int'(a[AW-1:2]);
  endfunction

  // A read may only be held back if a same-word write was accepted within the last WD cycles.
  function automatic logic blocked(input int w, input int c);
    foreach (hz_q[i]) begin
      if (hz_q[i].word == w && hz_q[i].cyc + WD >= c) return HAZ;
    end
    return 1'b0;
  endfunction

  task automatic check_cycle();
    logic [1:0]    elig;
    logic [1:0]    exp_rdy;
    logic [1:0]    ev;
    logic [1:0]    ew;
    logic [DW-1:0] ed [2];
    int            g;
    rsp_t          r;
    wr_t           w;
    acc = '0;
    if (!reset) begin
      chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
      chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'(0));
      chk("rst_ram_wstrb", 64'(ram_wstrb), 64'(0));
      chk("rst_ram_raddr", 64'(ram_raddr), 64'(0));
      exp_q.delete();
      hz_q.delete();
      last_m = 1'b1;
      return;
    end

    ev = '0; ew = '0; ed[0] = '0; ed[1] = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      ev[r.port] = 1'b1;
      ew[r.port] = r.write;
      ed[r.port] = r.data;
    end
    chk("resp_valid", 64'(bus.resp_valid), 64'(ev));
    chk("resp_write", 64'(bus.resp_write), 64'(ew));
    chk("resp_rdata0", 64'(bus.resp_rdata[0]), 64'(ed[0]));
    chk("resp_rdata1", 64'(bus.resp_rdata[1]), 64'(ed[1]));
    for (int p = 0; p < 2; p++) begin
      if (bus.resp_valid[p]) resp_seen[p] = bus.resp_rdata[p];
      if (bus.req_ready[p] && bus.req_valid[p]) begin
        obs_acc_cyc[p] = cyc;
        obs_grants.push_back(p);
      end
    end

    while (hz_q.size() > 0 && hz_q[0].cyc + WD < cyc) void'(hz_q.pop_front());
    for (int p = 0; p < 2; p++) begin
      elig[p] = bus.req_valid[p] && !(!bus.req_write[p] && blocked(word_of(bus.req_addr[p]), cyc));
    end
    if (elig == 2'b11)  g = last_m ? 0 : 1;
    else if (elig[0])   g = 0;
    else if (elig[1])   g = 1;
    else                g = -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));

    if (g < 0) begin
      chk("idle_ram_wstrb", 64'(ram_wstrb), 64'(0));
      chk("idle_ram_raddr", 64'(ram_raddr), 64'(0));
      chk("idle_ram_waddr", 64'(ram_waddr), 64'(0));
      chk("idle_ram_wdata", 64'(ram_wdata), 64'(0));
    end else begin
      acc[g] = 1'b1;
      last_m = (g == 1);
      r.due  = cyc + RD;
      r.port = g;
      if (bus.req_write[g]) begin
        chk("wr_ram_waddr", 64'(ram_waddr), 64'(bus.req_addr[g]));
        chk("wr_ram_wdata", 64'(ram_wdata), 64'(bus.req_wdata[g]));
        chk("wr_ram_wstrb", 64'(ram_wstrb), 64'(bus.req_wstrb[g]));
        w.cyc  = cyc;
        w.word = word_of(bus.req_addr[g]);
        w.data = bus.req_wdata[g];
        w.strb = bus.req_wstrb[g];
        pend_q.push_back(w);
        hz_q.push_back(w);
        r.write = 1'b1;
        r.data  = '0;
      end else begin
        chk("rd_ram_raddr", 64'(ram_raddr), 64'(bus.req_addr[g]));
        chk("rd_ram_wstrb", 64'(ram_wstrb), 64'(0));
        // The read sees every write that left the RAM delay line before this cycle.
        while (pend_q.size() > 0 && pend_q[0].cyc + WD < cyc) begin
          w = pend_q.pop_front();
          for (int b = 0; b < SW; b++) begin
            if (w.strb[b]) gold[w.word][8*b +: 8] = w.data[8*b +: 8];
          end
        end
        r.write = 1'b0;
        r.data  = gold[word_of(bus.req_addr[g])];
      end
      exp_q.push_back(r);
    end
  endtask

  task automatic step();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    cyc++;
    #1;
    for (int p = 0; p < 2; p++) if (acc[p]) bus.req_valid[p] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_req(input int p, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    bus.req_valid[p] = 1'b1;
    bus.req_write[p] = wr;
    bus.req_addr[p]  = a;
    bus.req_wdata[p] = d;
    bus.req_wstrb[p] = s;
  endtask

  task automatic run_until_idle(input int bound);
    for (int i = 0; i < bound && bus.req_valid != 2'b00; i++) step();
    chk("drain_timeout", 64'(bus.req_valid), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) gold[i] = '0;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    resp_seen[0] = '0;
    resp_seen[1] = '0;
    obs_acc_cyc[0] = 0;
    obs_acc_cyc[1] = 0;

    idle(3);
    reset = 1'b1;

    // Both ports reading back to back: grants alternate starting with port 0.
    obs_grants.delete();
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b0, AW'(32'h200 + 8 * i), '0, '0);
      set_req(1, 1'b0, AW'(32'h204 + 8 * i), '0, '0);
      step();
    end
    bus.req_valid = '0;
    idle(RD + 1);
    for (int i = 0; i < 8; i++) begin
      chk("alt_grant", 64'(obs_grants.size() > i ? obs_grants[i] : -1), 64'(i % 2));
    end

    // Read-after-write to the same word.
    set_req(0, 1'b1, 12'h040, 32'hDEADBEEF, 4'hF);
    run_until_idle(5);
    w_cyc = obs_acc_cyc[0];
    resp_seen[0] = '1;
    set_req(0, 1'b0, 12'h040, '0, '0);
    run_until_idle(10);
    chk("raw_read_delay", 64'(obs_acc_cyc[0] - w_cyc), 64'(HAZ ? WD + 1 : 1));
    idle(RD + 1);
    chk("raw_read_data", 64'(resp_seen[0]), 64'(HAZ ? 32'hDEADBEEF : 32'h0));

    // Preferred port blocked by a pending write must not starve the other port.
    idle(WD + 2);
    set_req(1, 1'b1, 12'h080, 32'h12345678, 4'hF);
    run_until_idle(5);
    obs_grants.delete();
    set_req(0, 1'b0, 12'h080, '0, '0);
    set_req(1, 1'b0, 12'h100, '0, '0);
    step();
    chk("blocked_pref_grant", 64'(obs_grants.size() > 0 ? obs_grants[0] : -1), 64'(HAZ ? 1 : 0));
    run_until_idle(10);
    idle(RD + 1);

    // Partial write merges with the existing word.
    idle(WD + 2);
    set_req(0, 1'b1, 12'h000, 32'hAABBCCDD, 4'hF);
    run_until_idle(5);
    set_req(0, 1'b1, 12'h000, 32'h11223344, 4'h3);
    run_until_idle(5);
    idle(WD + 1);
    resp_seen[0] = '1;
    set_req(0, 1'b0, 12'h000, '0, '0);
    run_until_idle(10);
    idle(RD + 1);
    chk("partial_data", 64'(resp_seen[0]), 64'(32'hAABB3344));

    // Reset with two reads in flight; last grant before reset goes to port 0.
    set_req(1, 1'b0, 12'h010, '0, '0);
    run_until_idle(5);
    set_req(0, 1'b0, 12'h014, '0, '0);
    run_until_idle(5);
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(RD + 2);
    obs_grants.delete();
    set_req(0, 1'b0, 12'h020, '0, '0);
    set_req(1, 1'b0, 12'h024, '0, '0);
    step();
    chk("post_reset_grant", 64'(obs_grants.size() > 0 ? obs_grants[0] : -1), 64'(0));
    run_until_idle(5);
    idle(RD + 1);

    // Random traffic over a handful of words to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!bus.req_valid[p] && $urandom_range(0, 3) != 0) begin
          set_req(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom,
                  SW'($urandom_range(0, 15)));
        end
      end
      step();
    end
    bus.req_valid = '0;
    idle(RD + 2);
    chk("final_exp_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
